// File: rtl/adc_sequencer.sv
// rtl/adc_sequencer.sv - SAR ADC phase sequencer: init/sample/compare/update timing and result handshake
module adc_sequencer #(
  parameter int MAXBITS = 16,
  parameter int SAMPW   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               cfg_continuous,
  input  logic [SAMPW-1:0]   cfg_samp_cycles,
  input  logic [4:0]         cfg_comp_cycles,
  input  logic               comp_out,
  output logic               seq_init,
  output logic               seq_samp,
  output logic               seq_comp,
  output logic               seq_update,
  output logic               busy,
  output logic [MAXBITS-1:0] result_data,
  output logic               result_valid,
  input  logic               result_ready,
  output logic               overrun
);

  localparam int NW = $clog2(MAXBITS + 1);

  // One-hot so every phase output is a direct copy of a state flop.
  typedef enum logic [5:0] {
    IDLE = 6'b000001,
    INIT = 6'b000010,
    SAMP = 6'b000100,
    COMP = 6'b001000,
    UPD  = 6'b010000,
    DONE = 6'b100000
  } state_t;

  state_t state, next_state;

  logic [SAMPW-1:0]   s_lat, samp_cnt, s_cfg;
  logic [NW-1:0]      n_lat, bit_cnt, n_cfg;
  logic [MAXBITS-1:0] sr;
  logic               latch, load;

  always_comb begin
    s_cfg = (cfg_samp_cycles == '0) ? SAMPW'(1) : cfg_samp_cycles;
    if (cfg_comp_cycles == 5'd0)
      n_cfg = NW'(1);
    else if (32'(cfg_comp_cycles) > MAXBITS)
      n_cfg = NW'(MAXBITS);
    else
      n_cfg = NW'(cfg_comp_cycles);
  end

  assign latch = ((state == IDLE) && start) || ((state == DONE) && cfg_continuous);
  assign load  = (state == UPD) && (bit_cnt == n_lat);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = INIT;
      INIT:    next_state = SAMP;
      SAMP:    if (samp_cnt == s_lat - SAMPW'(1)) next_state = COMP;
      COMP:    next_state = UPD;
      UPD:     next_state = (bit_cnt == n_lat) ? DONE : COMP;
      DONE:    next_state = cfg_continuous ? INIT : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    seq_init   = (state == INIT);
    seq_samp   = (state == SAMP);
    seq_comp   = (state == COMP);
    seq_update = (state == UPD);
    busy       = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_lat        <= '0;
      n_lat        <= '0;
      samp_cnt     <= '0;
      bit_cnt      <= '0;
      sr           <= '0;
      result_data  <= '0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (latch) begin
        s_lat   <= s_cfg;
        n_lat   <= n_cfg;
        sr      <= '0;
        bit_cnt <= '0;
      end
      if (state == INIT)
        samp_cnt <= '0;
      else if (state == SAMP)
        samp_cnt <= samp_cnt + SAMPW'(1);
      // Bits above N stay zero because sr is cleared at latch and shifted only N times.
      if (state == COMP) begin
        sr      <= {sr[MAXBITS-2:0], comp_out};
        bit_cnt <= bit_cnt + NW'(1);
      end
      if (load) begin
        result_data  <= sr;
        result_valid <= 1'b1;
        if (result_valid && !result_ready)
          overrun <= 1'b1;
      end else if (result_valid && result_ready) begin
        result_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adc_sequencer.sv
// tb/tb_adc_sequencer.sv - randomized scoreboard bench for adc_sequencer
module tb_adc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        cfg_continuous = 1'b0;
  logic [7:0]  cfg_samp_cycles = 8'd1;
  logic [4:0]  cfg_comp_cycles = 5'd1;
  logic        comp_out = 1'b0;
  logic        seq_init, seq_samp, seq_comp, seq_update, busy;
  logic [15:0] result_data;
  logic        result_valid;
  logic        result_ready = 1'b0;
  logic        overrun;

  adc_sequencer #(.MAXBITS(16), .SAMPW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_continuous(cfg_continuous),
    .cfg_samp_cycles(cfg_samp_cycles), .cfg_comp_cycles(cfg_comp_cycles),
    .comp_out(comp_out), .seq_init(seq_init), .seq_samp(seq_samp),
    .seq_comp(seq_comp), .seq_update(seq_update), .busy(busy),
    .result_data(result_data), .result_valid(result_valid),
    .result_ready(result_ready), .overrun(overrun)
  );

  initial forever #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int c0 = 0;
  int n_init, n_samp, n_comp, n_upd;
  int overlap_err = 0;
  int valid_rise = -1;
  int busy_fall = -1;
  int init_rises[$];
  bit bits_q[$];
  logic [15:0] exp_q[$];
  logic prev_init = 0, prev_valid = 0, prev_busy = 0;
  logic [15:0] w1, w2, wx;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Comparator stand-in: supplies the queued decision for each COMP cycle.
  initial forever begin
    @(negedge clk);
    if (seq_comp && !rst)
      comp_out = (bits_q.size() > 0) ? bits_q.pop_front() : 1'b0;
  end

  // Monitor: phase statistics and scoreboard pops on every handshake transfer.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if ($countones({seq_init, seq_samp, seq_comp, seq_update}) > 1) overlap_err++;
      n_init += int'(seq_init);
      n_samp += int'(seq_samp);
      n_comp += int'(seq_comp);
      n_upd  += int'(seq_update);
      if (seq_init && !prev_init) init_rises.push_back(cyc);
      if (result_valid && !prev_valid) valid_rise = cyc;
      if (!busy && prev_busy) busy_fall = cyc;
      if (result_valid && result_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL xfer_unexpected actual=%0h required=none", result_data);
        end else begin
          check("xfer_data", {16'h0, result_data}, {16'h0, exp_q.pop_front()});
        end
      end
    end
    prev_init  = seq_init;
    prev_valid = result_valid;
    prev_busy  = busy;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_until(input int t);
    for (int i = 0; i < 1000 && cyc < t; i++) tick(1);
  endtask

  task automatic reset_counts();
    n_init = 0; n_samp = 0; n_comp = 0; n_upd = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    c0 = cyc;
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit && busy; i++) tick(1);
    check("idle_timeout", {31'h0, busy}, 32'h0);
    tick(1);
  endtask

  // Reference: decision k of an N-bit conversion is worth 2^(N-1-k).
  task automatic queue_conv(input int n, input bit fixed, input logic [15:0] pat,
                            input bit expect_it, output logic [15:0] w);
    bit b;
    w = 16'h0;
    for (int k = 0; k < n; k++) begin
      b = fixed ? pat[n-1-k] : bit'($urandom % 2);
      bits_q.push_back(b);
      if (b) w = w + 16'(1 << (n - 1 - k));
    end
    if (expect_it) exp_q.push_back(w);
  endtask

  task automatic async_reset_check(input string name);
    #2 rst = 1'b1;
    #1;
    check({name, "_seq_busy_flags"},
          {25'h0, seq_init, seq_samp, seq_comp, seq_update, busy, result_valid, overrun}, 32'h0);
    check({name, "_data"}, {16'h0, result_data}, 32'h0);
    tick(2);
    rst = 1'b0;
    bits_q.delete();
    reset_counts();
    tick(6);
    check({name, "_quiet_after"}, n_init + n_samp + n_comp + n_upd + int'(busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(2);
    check("reset_outputs",
          {25'h0, seq_init, seq_samp, seq_comp, seq_update, busy, result_valid, overrun}, 32'h0);
    check("reset_data", {16'h0, result_data}, 32'h0);
    rst = 1'b0;
    tick(2);

    // Single conversion S=4 N=8, with an ignored start mid-conversion.
    cfg_samp_cycles = 8'd4; cfg_comp_cycles = 5'd8; cfg_continuous = 1'b0;
    queue_conv(8, 1'b1, 16'h00B2, 1'b1, wx);
    reset_counts();
    pulse_start();
    tick(4);
    start = 1'b1; tick(1); start = 1'b0;
    wait_idle(100);
    check("t1_valid_time", valid_rise - c0, 21);
    check("t1_busy_fall", busy_fall - c0, 22);
    check("t1_counts", {n_init[7:0], n_samp[7:0], n_comp[7:0], n_upd[7:0]}, 32'h01040808);
    check("t1_data", {16'h0, result_data}, 32'h00B2);
    check("t1_valid", {31'h0, result_valid}, 32'h1);
    result_ready = 1'b1; tick(1); result_ready = 1'b0;
    check("t1_valid_cleared", {31'h0, result_valid}, 32'h0);

    // Config clamp: S=0 -> 1, N=31 -> 16.
    cfg_samp_cycles = 8'd0; cfg_comp_cycles = 5'd31;
    queue_conv(16, 1'b1, 16'hFFFF, 1'b1, wx);
    reset_counts();
    pulse_start();
    cfg_samp_cycles = 8'd9; cfg_comp_cycles = 5'd3;
    wait_idle(100);
    check("t2_valid_time", valid_rise - c0, 34);
    check("t2_samp_cnt", n_samp, 1);
    check("t2_comp_cnt", n_comp, 16);
    check("t2_data", {16'h0, result_data}, 32'hFFFF);
    result_ready = 1'b1; tick(1); result_ready = 1'b0;

    // Continuous S=2 N=4, always ready, stop during the third conversion.
    cfg_samp_cycles = 8'd2; cfg_comp_cycles = 5'd4; cfg_continuous = 1'b1;
    result_ready = 1'b1;
    for (int i = 0; i < 3; i++) queue_conv(4, 1'b0, 16'h0, 1'b1, wx);
    init_rises.delete();
    pulse_start();
    for (int i = 0; i < 100 && init_rises.size() < 3; i++) tick(1);
    cfg_continuous = 1'b0;
    wait_idle(100);
    check("t3_init_count", init_rises.size(), 3);
    if (init_rises.size() >= 3) begin
      check("t3_init0", init_rises[0] - c0, 0);
      check("t3_init1", init_rises[1] - c0, 12);
      check("t3_init2", init_rises[2] - c0, 24);
    end
    check("t3_busy_fall", busy_fall - c0, 36);
    check("t3_overrun", {31'h0, overrun}, 32'h0);
    tick(2);
    check("t3_drained", exp_q.size(), 0);
    result_ready = 1'b0;

    // Simultaneous load and accept on the second result's load edge.
    cfg_continuous = 1'b1;
    queue_conv(4, 1'b0, 16'h0, 1'b1, w1);
    queue_conv(4, 1'b0, 16'h0, 1'b1, w2);
    pulse_start();
    tick_until(c0 + 13);
    cfg_continuous = 1'b0;
    tick_until(c0 + 22);
    result_ready = 1'b1;
    tick(1);
    result_ready = 1'b0;
    check("t4_valid_held", {31'h0, result_valid}, 32'h1);
    check("t4_new_word", {16'h0, result_data}, {16'h0, w2});
    check("t4_no_overrun", {31'h0, overrun}, 32'h0);
    wait_idle(50);
    result_ready = 1'b1; tick(1); result_ready = 1'b0;
    check("t4_drained", exp_q.size(), 0);

    // Overrun: continuous with no consumer; the first word is lost.
    cfg_samp_cycles = 8'd1; cfg_comp_cycles = 5'd2; cfg_continuous = 1'b1;
    queue_conv(2, 1'b0, 16'h0, 1'b0, w1);
    queue_conv(2, 1'b0, 16'h0, 1'b1, w2);
    pulse_start();
    tick_until(c0 + 8);
    cfg_continuous = 1'b0;
    wait_idle(50);
    check("t5_overrun_set", {31'h0, overrun}, 32'h1);
    check("t5_data_new", {16'h0, result_data}, {16'h0, w2});
    result_ready = 1'b1; tick(1); result_ready = 1'b0;
    check("t5_valid_cleared", {31'h0, result_valid}, 32'h0);
    check("t5_overrun_sticky", {31'h0, overrun}, 32'h1);

    // Reset mid-SAMP.
    cfg_samp_cycles = 8'd10; cfg_comp_cycles = 5'd4;
    queue_conv(4, 1'b0, 16'h0, 1'b0, wx);
    pulse_start();
    tick(4);
    async_reset_check("t6_rst_samp");

    // Reset mid-COMP.
    cfg_samp_cycles = 8'd1; cfg_comp_cycles = 5'd8;
    queue_conv(8, 1'b0, 16'h0, 1'b0, wx);
    pulse_start();
    for (int i = 0; i < 20 && !seq_comp; i++) tick(1);
    tick(2);
    async_reset_check("t7_rst_comp");

    check("final_scoreboard_empty", exp_q.size(), 0);
    check("final_no_overlap", overlap_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
